enigma_rotor_core: RTL and testbench

- Cipher engine on the far side of the enigma wrapper. It accepts one symbol per cycle from the wrapper's enigma-feed interface and returns the encoded symbol on the wrapper's encoded-symbol input interface.
- Models a three-rotor, reflector-based, self-reciprocal substitution with odometer stepping. The same key encodes and decodes.
- Symbol alphabet is 1..26; 0 means "no symbol".

---
 rtl/enigma_rotor_core_if.sv | 13 +
 rtl/enigma_rotor_core.sv | 112 +++++++++++
 tb/tb_enigma_rotor_core.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_rotor_core_if.sv
// Symbol stream between the enigma wrapper and the rotor core.
// Signal names follow the core's port names so both sides read the same.
interface enigma_rotor_core_if #(
    parameter int SYMB_W = 7
);
    logic [SYMB_W-1:0] in_en_i;
    logic              en_val_i;
    logic [SYMB_W-1:0] out_en_o;
    logic              encod_val_o;

    modport master (output in_en_i, en_val_i, input out_en_o, encod_val_o);
    modport slave  (input in_en_i, en_val_i, output out_en_o, encod_val_o);
endinterface

// File: rtl/enigma_rotor_core.sv
// Three-rotor reflector cipher: self-reciprocal substitution with odometer stepping.
// Two-stage pipeline, one symbol per cycle, no backpressure.
module enigma_rotor_core #(
    parameter int SYMB_W = 7,
    parameter int ALPH   = 26
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                key_load_i,
    input  logic [14:0]         key_i,
    enigma_rotor_core_if.slave  sym_if,
    output logic                err_o,
    output logic [14:0]         pos_o,
    output logic [7:0]          symb_cnt_o
);

    // Reduce 0..3*ALPH-1 into 0..ALPH-1 without a divider.
    function automatic logic [4:0] mod_alph(input logic [6:0] v);
        if (v >= 7'(2 * ALPH))
            return 5'(v - 7'(2 * ALPH));
        else if (v >= 7'(ALPH))
            return 5'(v - 7'(ALPH));
        else
            return 5'(v);
    endfunction

    function automatic logic [4:0] inc_rotor(input logic [4:0] p);
        return (p == 5'(ALPH - 1)) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [14:0] step_pos(input logic [14:0] p);
        logic [4:0] n0, n1, n2;
        n0 = inc_rotor(p[4:0]);
        n1 = (p[4:0] == 5'(ALPH - 1)) ? inc_rotor(p[9:5]) : p[9:5];
        n2 = (p[4:0] == 5'(ALPH - 1) && p[9:5] == 5'(ALPH - 1)) ? inc_rotor(p[14:10]) : p[14:10];
        return {n2, n1, n0};
    endfunction

    logic [14:0] pos_q, pos_d, pos_base;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        sym_ok, key_ok, load_ok;
    logic [4:0]  s_p0, psum_p0;
    logic [6:0]  sum_p0;

    logic        vld_p1_q;
    logic [4:0]  s_p1_q, psum_p1_q;
    logic [6:0]  yraw_p1;
    logic [4:0]  y_p1;

    logic              vld_p2_q;
    logic [SYMB_W-1:0] out_en_p2_q, out_en_p2_d;

    always_comb begin
        sym_ok  = sym_if.en_val_i && (sym_if.in_en_i != '0) &&
                  (sym_if.in_en_i <= SYMB_W'(ALPH));
        key_ok  = (key_i[4:0] <= 5'(ALPH - 1)) && (key_i[9:5] <= 5'(ALPH - 1)) &&
                  (key_i[14:10] <= 5'(ALPH - 1));
        load_ok = key_load_i && key_ok;
        err_d   = (sym_if.en_val_i && !sym_ok) || (key_load_i && !key_ok);

        // A valid key in the same cycle as a symbol is used for that symbol.
        pos_base = load_ok ? key_i : pos_q;
        pos_d    = sym_ok ? step_pos(pos_base) : pos_base;
        if (load_ok)
            cnt_d = sym_ok ? 8'd1 : 8'd0;
        else
            cnt_d = cnt_q + {7'd0, sym_ok};

        s_p0    = 5'(sym_if.in_en_i - SYMB_W'(1));
        sum_p0  = {2'b00, pos_base[4:0]} + {2'b00, pos_base[9:5]} + {2'b00, pos_base[14:10]};
        psum_p0 = mod_alph(sum_p0);
    end

    // 77 - s - 2P is congruent to 25 - s - 2P and stays in 2..77.
    always_comb begin
        yraw_p1     = 7'(3 * ALPH - 1) - {2'b00, s_p1_q} - {1'b0, psum_p1_q, 1'b0};
        y_p1        = mod_alph(yraw_p1);
        out_en_p2_d = vld_p1_q ? (SYMB_W'(y_p1) + SYMB_W'(1)) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_en_p2_q <= '0;
        end else begin
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            vld_p1_q    <= sym_ok;
            vld_p2_q    <= vld_p1_q;
            out_en_p2_q <= out_en_p2_d;
        end
    end

    // Stage 1 data: qualified by vld_p1_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        s_p1_q    <= s_p0;
        psum_p1_q <= psum_p0;
    end

    assign sym_if.out_en_o    = out_en_p2_q;
    assign sym_if.encod_val_o = vld_p2_q;
    assign err_o              = err_q;
    assign pos_o              = pos_q;
    assign symb_cnt_o         = cnt_q;

endmodule

// File: tb/tb_enigma_rotor_core.sv
// Directed bench for enigma_rotor_core with a queue scoreboard on the output stream.
module tb_enigma_rotor_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_load;
    logic [14:0] key_v;
    logic        err;
    logic [14:0] pos;
    logic [7:0]  cnt;

    enigma_rotor_core_if #(.SYMB_W(7)) sym_if ();

    enigma_rotor_core #(.SYMB_W(7), .ALPH(26)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .key_load_i (key_load),
        .key_i      (key_v),
        .sym_if     (sym_if),
        .err_o      (err),
        .pos_o      (pos),
        .symb_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp_out;
        int din;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mp0 = 0, mp1 = 0, mp2 = 0, mcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int enc(input int sym, input int a, input int b, input int c);
        int p, y;
        p = (a + b + c) % 26;
        y = (25 - (sym - 1) - 2 * p) % 26;
        if (y < 0) y += 26;
        return y + 1;
    endfunction

    function automatic logic [14:0] kpack(input int a, input int b, input int c);
        return {5'(c), 5'(b), 5'(a)};
    endfunction

    // Output monitor: every valid output must match the head of the scoreboard.
    exp_t e;
    always @(negedge clk) begin
        if (sym_if.encod_val_o === 1'b1) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_out observed=%0d expected=no output", sym_if.out_en_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_assert++;
                assert (int'(sym_if.out_en_o) == e.exp_out && cyc == e.due && int'(sym_if.out_en_o) != e.din)
                else begin
                    n_fail++;
                    $error("FAIL out_en observed=%0d@cyc%0d expected=%0d@cyc%0d (input %0d)",
                           sym_if.out_en_o, cyc, e.exp_out, e.due, e.din);
                end
            end
        end else begin
            n_assert++;
            assert (sym_if.out_en_o === 7'd0) else begin
                n_fail++;
                $error("FAIL out_idle_zero observed=%0d expected=0", sym_if.out_en_o);
            end
        end
    end

    // Drive one cycle of inputs, update the model, then check control state after the edge.
    task automatic step(input bit kl, input logic [14:0] kv, input bit val, input int sym);
        bit kok, sok, exp_err;
        key_load         = kl;
        key_v            = kv;
        sym_if.en_val_i  = val;
        sym_if.in_en_i   = 7'(sym);
        kok = (kv[4:0] <= 5'd25) && (kv[9:5] <= 5'd25) && (kv[14:10] <= 5'd25);
        sok = val && (sym >= 1) && (sym <= 26);
        exp_err = (val && !sok) || (kl && !kok);
        if (kl && kok) begin
            mp0 = int'(kv[4:0]); mp1 = int'(kv[9:5]); mp2 = int'(kv[14:10]);
            mcnt = 0;
        end
        if (sok) begin
            sb.push_back('{enc(sym, mp0, mp1, mp2), sym, cyc + 2});
            mp0 = (mp0 + 1) % 26;
            if (mp0 == 0) begin
                mp1 = (mp1 + 1) % 26;
                if (mp1 == 0) mp2 = (mp2 + 1) % 26;
            end
            mcnt = (mcnt + 1) % 256;
        end
        @(posedge clk);
        #1;
        n_assert++;
        assert (err === exp_err) else begin
            n_fail++;
            $error("FAIL err_o observed=%0b expected=%0b", err, exp_err);
        end
        n_assert++;
        assert (pos === kpack(mp0, mp1, mp2)) else begin
            n_fail++;
            $error("FAIL pos_o observed=%h expected=%h", pos, kpack(mp0, mp1, mp2));
        end
        n_assert++;
        assert (cnt === 8'(mcnt)) else begin
            n_fail++;
            $error("FAIL symb_cnt observed=%0d expected=%0d", cnt, mcnt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 15'd0, 1'b0, 0);
    endtask

    initial begin
        int a, b, c, enc_v;
        rst_n           = 1'b0;
        key_load        = 1'b0;
        key_v           = '0;
        sym_if.en_val_i = 1'b0;
        sym_if.in_en_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        assert (sym_if.encod_val_o === 1'b0 && sym_if.out_en_o === 7'd0 && err === 1'b0 &&
                pos === 15'd0 && cnt === 8'd0) else begin
            n_fail++;
            $error("FAIL reset_state observed=%b/%0d/%b/%h/%0d expected=all zero",
                   sym_if.encod_val_o, sym_if.out_en_o, err, pos, cnt);
        end
        rst_n = 1'b1;
        idle(2);

        // Key (0,0,0), three 1s back to back -> 26, 24, 22.
        step(1'b1, kpack(0, 0, 0), 1'b1, 1);
        step(1'b0, 15'd0, 1'b1, 1);
        step(1'b0, 15'd0, 1'b1, 1);
        idle(3);

        // Odometer carries.
        step(1'b1, kpack(25, 0, 0), 1'b1, 1);
        idle(2);
        step(1'b1, kpack(25, 25, 25), 1'b1, 5);
        idle(2);

        // Reciprocity with a fixed key.
        step(1'b1, kpack(3, 4, 5), 1'b1, 1);
        step(1'b1, kpack(3, 4, 5), 1'b1, 2);
        idle(2);

        // Sweep all symbols at random keys: encode, then decode must return the original.
        for (int k = 0; k < 3; k++) begin
            a = $urandom_range(0, 25);
            b = $urandom_range(0, 25);
            c = $urandom_range(0, 25);
            for (int s = 1; s <= 26; s++) begin
                enc_v = enc(s, a, b, c);
                step(1'b1, kpack(a, b, c), 1'b1, s);
                step(1'b1, kpack(a, b, c), 1'b1, enc_v);
                n_assert++;
                assert (sb[sb.size() - 1].exp_out == s) else begin
                    n_fail++;
                    $error("FAIL reciprocity observed=%0d expected=%0d", sb[sb.size() - 1].exp_out, s);
                end
            end
        end
        idle(3);

        // Invalid symbols: error pulses, nothing else moves.
        step(1'b0, 15'd0, 1'b1, 0);
        step(1'b0, 15'd0, 1'b1, 27);
        idle(3);

        // Bad key field, then key load with a simultaneous symbol (P=7 -> 12).
        step(1'b1, kpack(0, 26, 0), 1'b0, 0);
        step(1'b1, kpack(7, 0, 0), 1'b1, 1);
        n_assert++;
        assert (sb.size() != 0 && sb[sb.size() - 1].exp_out == 12) else begin
            n_fail++;
            $error("FAIL key_sym_same_cycle expected out 12 queued=%0d", sb.size());
        end
        idle(3);

        // Reset with two symbols in flight.
        step(1'b0, 15'd0, 1'b1, 3);
        step(1'b0, 15'd0, 1'b1, 4);
        key_load = 1'b0; sym_if.en_val_i = 1'b0; sym_if.in_en_i = '0;
        n_assert++;
        assert (sym_if.encod_val_o === 1'b1) else begin
            n_fail++;
            $error("FAIL inflight_before_reset observed=%b expected=1", sym_if.encod_val_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_assert++;
        assert (sym_if.encod_val_o === 1'b0 && sym_if.out_en_o === 7'd0 &&
                pos === 15'd0 && cnt === 8'd0) else begin
            n_fail++;
            $error("FAIL async_reset observed=%b/%0d/%h/%0d expected=all zero",
                   sym_if.encod_val_o, sym_if.out_en_o, pos, cnt);
        end
        sb.delete();
        mp0 = 0; mp1 = 0; mp2 = 0; mcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Drain, bounded.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain observed=%0d pending expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
